// File: rtl/instr_fetch.sv
// Sequential instruction fetcher: streams big-endian 32-bit words from a preloaded
// byte memory to a CPU over a valid/ready handshake. Define FETCH_REDIRECT_EN for PC redirect.
module instr_fetch #(
  parameter int INSTR_MAX = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        instr_ready,
`ifdef FETCH_REDIRECT_EN
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
`endif
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        instr_valid,
  output logic        done
);

  // Handshake: instr/instr_addr are offered while instr_valid=1 and are consumed on
  // any rising edge where instr_ready=1; while not consumed they hold unchanged.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int          AW       = $clog2(INSTR_MAX);
  localparam logic [31:0] LAST_ADDR = 32'(INSTR_MAX - 4);

  // Written only by the bench through hierarchy.
  logic [7:0]  InstrMem [0:INSTR_MAX-1];

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] fetchWord;
  logic        slotFree;
  logic        pcInRange;

  // pc is word aligned, so the byte lanes are formed by replacing the low two bits.
  always_comb begin
    fetchWord = {InstrMem[{pc[AW-1:2], 2'b00}], InstrMem[{pc[AW-1:2], 2'b01}],
                 InstrMem[{pc[AW-1:2], 2'b10}], InstrMem[{pc[AW-1:2], 2'b11}]};
    slotFree  = !instr_valid || instr_ready;
    pcInRange = (pc <= LAST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
`ifdef FETCH_REDIRECT_EN
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            pc          <= {redirect_addr[31:2], 2'b00};
          end else
`endif
          if (slotFree && pcInRange) begin
            instr       <= fetchWord;
            instr_addr  <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
          end else if (slotFree) begin
            // Last word consumed (or nothing pending after an out-of-range redirect).
            instr_valid <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: streaming, backpressure, completion,
// mid-run reset and, when FETCH_REDIRECT_EN is defined, redirect behaviour.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic        done;

  logic [7:0]  mem [0:127];
  logic [31:0] exp_q[$];
  int          nChecks = 0;
  int          nPass = 0;

  instr_fetch #(.INSTR_MAX(128)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .instr_ready(instr_ready),
`ifdef FETCH_REDIRECT_EN
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
`endif
    .instr(instr),
    .instr_addr(instr_addr),
    .instr_valid(instr_valid),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else nPass++;
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {mem[a[6:0]], mem[a[6:0] + 7'd1], mem[a[6:0] + 7'd2], mem[a[6:0] + 7'd3]};
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_addr"}, instr_addr, 32'h0);
    check({tag, "_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitAddr(input logic [31:0] a, input string tag);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (instr_valid && instr_addr == a) found = 1'b1;
    end
    check({tag, "_reached"}, 32'(found), 32'h1);
  endtask

  initial begin
    int firstCyc;
    int lastCyc;
    logic [31:0] e;

    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h00; mem[1] = 8'h22; mem[2] = 8'h88; mem[3] = 8'h20;
    for (int i = 0; i < 128; i++) dut.InstrMem[i] = mem[i];

    // Full stream with ready held high
    doReset();
    checkZero("reset");
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(4 * i));
    instr_ready = 1'b1;
    pulseStart();
    check("start_no_fetch", 32'(instr_valid), 32'h0);
    firstCyc = -1;
    lastCyc = -1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_word", instr_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("stream_addr", instr_addr, e);
          check("stream_data", instr, memWord(e));
          if (e == 32'h0) check("first_word", instr, 32'h0022_8820);
          if (firstCyc < 0) firstCyc = c;
          lastCyc = c;
        end
      end
    end
    check("all_words", 32'(exp_q.size()), 32'h0);
    check("first_latency", 32'(firstCyc), 32'h0);
    check("no_bubbles", 32'(lastCyc - firstCyc), 32'd31);
    check("end_done", 32'(done), 32'h1);
    check("end_valid", 32'(instr_valid), 32'h0);

    // DONE is sticky and ignores start / ready
    for (int c = 0; c < 6; c++) begin
      start = c[0];
      instr_ready = ~instr_ready;
      @(negedge clk);
      check("done_hold", 32'(done), 32'h1);
      check("done_valid", 32'(instr_valid), 32'h0);
      check("done_addr", instr_addr, 32'h7C);
      check("done_instr", instr, memWord(32'h7C));
    end
    start = 1'b0;

    // Backpressure at 0x08, then reset mid-run at 0x40
    doReset();
    checkZero("reset2");
    instr_ready = 1'b1;
    pulseStart();
    waitAddr(32'h08, "bp");
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(instr_valid), 32'h1);
      check("bp_addr", instr_addr, 32'h08);
      check("bp_instr", instr, memWord(32'h08));
    end
    instr_ready = 1'b1;
    @(negedge clk);
    check("bp_next_addr", instr_addr, 32'h0C);
    check("bp_next_instr", instr, memWord(32'h0C));
    waitAddr(32'h40, "mid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkZero("mid_reset");
    pulseStart();
    @(negedge clk);
    check("restart_valid", 32'(instr_valid), 32'h1);
    check("restart_addr", instr_addr, 32'h0);

`ifdef FETCH_REDIRECT_EN
    // Redirect taken together with an acceptance: 0x14 must never appear
    doReset();
    instr_ready = 1'b1;
    pulseStart();
    waitAddr(32'h10, "rd1");
    redirect_valid = 1'b1;
    redirect_addr = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd1_bubble", 32'(instr_valid), 32'h0);
    @(negedge clk);
    check("rd1_valid", 32'(instr_valid), 32'h1);
    check("rd1_addr", instr_addr, 32'h40);
    check("rd1_instr", instr, memWord(32'h40));

    // Unaligned target is aligned down; out-of-range target finishes
    doReset();
    instr_ready = 1'b1;
    pulseStart();
    waitAddr(32'h10, "rd2");
    redirect_valid = 1'b1;
    redirect_addr = 32'h23;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd2_bubble", 32'(instr_valid), 32'h0);
    @(negedge clk);
    check("rd2_addr", instr_addr, 32'h20);
    check("rd2_instr", instr, memWord(32'h20));
    redirect_valid = 1'b1;
    redirect_addr = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd3_valid", 32'(instr_valid), 32'h0);
    check("rd3_not_done", 32'(done), 32'h0);
    @(negedge clk);
    check("rd3_done", 32'(done), 32'h1);
    check("rd3_valid2", 32'(instr_valid), 32'h0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter INSTR_MAX, default 128, SHALL set the instruction memory size in bytes (multiple of 4, ≥8).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous and active-high.
REQ-004 Port start, input, 1, SHALL request that fetching begin from address 0.
REQ-005 Port instr_ready, input, 1, SHALL indicate that the downstream CPU accepts instr this cycle.
REQ-006 Port redirect_valid, input, 1, SHALL request a PC redirect. Present only with FETCH_REDIRECT_EN.
REQ-007 Port redirect_addr, input, 32, SHALL give the redirect target byte address. Present only with FETCH_REDIRECT_EN.
REQ-008 Port instr, output, 32, SHALL carry the registered fetched instruction word.
REQ-009 Port instr_addr, output, 32, SHALL carry the byte address of instr.
REQ-010 Port instr_valid, output, 1, SHALL indicate that instr/instr_addr are valid.
REQ-011 Port done, output, 1, SHALL indicate that all instructions have been delivered.
REQ-012 Memory InstrMem[0:INSTR_MAX-1], 8 bits per entry, SHALL be preloadable by the bench through hierarchy; it has no write port.

Function
REQ-013 States SHALL be IDLE, RUN and DONE.
REQ-014 IDLE SHALL move to RUN on the edge where start=1; no fetch occurs on that edge.
REQ-015 Internal pc SHALL hold the next fetch address, 32 bits, with pc[1:0] always 0.
REQ-016 Word assembly SHALL be big-endian: {InstrMem[pc], InstrMem[pc+1], InstrMem[pc+2], InstrMem[pc+3]}, with InstrMem[pc] in bits 31:24.
REQ-017 In RUN, define L = (!instr_valid || instr_ready) && pc <= INSTR_MAX-4.
- When L holds: instr<=word(pc), instr_addr<=pc, instr_valid<=1, pc<=pc+4.
REQ-018 In RUN, when instr_valid && instr_ready && pc > INSTR_MAX-4: instr_valid<=0, done<=1, state->DONE.
REQ-019 While instr_valid=1 and instr_ready=0, instr, instr_addr and pc SHALL hold unchanged.
REQ-020 Latency: start sampled at edge k SHALL give instr_valid=1 with instr_addr=0 after edge k+1.
REQ-021 With instr_ready held at 1, one instruction SHALL be delivered per cycle with no bubbles.
REQ-022 DONE SHALL persist until rst; start and instr_ready are ignored in DONE.
REQ-023 In RUN, start SHALL be ignored.
REQ-024 pc+4 SHALL wrap modulo 2^32; the INSTR_MAX bound check prevents wrap in normal operation.

Reset
REQ-025 rst=1 at an edge SHALL force: state=IDLE, pc=0, instr=0, instr_addr=0, instr_valid=0, done=0.
REQ-026 rst SHALL take priority over start, instr_ready and redirect_valid, including mid-RUN and in DONE.

Configuration
REQ-027 Macro FETCH_REDIRECT_EN SHALL include the redirect ports and redirect logic when defined.
REQ-028 With FETCH_REDIRECT_EN, redirect_valid=1 in RUN SHALL have priority over REQ-017/018:
- instr_valid<=0
- pc<={redirect_addr[31:2],2'b00}
- fetch resumes under REQ-017 on the following edge.
- If the target is > INSTR_MAX-4, the next edge SHALL enter DONE with done=1.
REQ-029 With FETCH_REDIRECT_EN, redirect_valid SHALL be ignored in IDLE and DONE.
REQ-030 Without FETCH_REDIRECT_EN, the redirect ports SHALL be absent and pc SHALL advance only by +4.

Verification
REQ-031 Preload bytes 0..3 = 00 22 88 20, rst, start, instr_ready=1 -> instr=0x00228820, instr_addr=0 two edges after start; 32 consecutive words 0x00..0x7C; then done=1, instr_valid=0.
REQ-032 instr_ready=0 for 3 cycles while instr_addr=0x08 -> instr/instr_addr stable; after ready returns, the next word has instr_addr=0x0C.
REQ-033 Acceptance at instr_addr=0x7C -> next cycle instr_valid=0, done=1; later start pulses and instr_ready toggles leave outputs unchanged.
REQ-034 rst=1 while instr_addr=0x40 -> all outputs 0 next cycle; start again -> first instr_addr=0x00.
REQ-035 With FETCH_REDIRECT_EN: redirect_addr=0x23 while valid at 0x10 -> instr_valid drops for one cycle, next instr_addr=0x20; redirect_addr=0x80 -> done=1.
REQ-036 Simultaneous redirect_valid=1 and instr_ready=1 at instr_addr=0x10 with target 0x40 -> no word from 0x14 is ever presented; next valid instr_addr=0x40.
